// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative multiply/divide unit with HI/LO result registers
//
// Purpose: EX-stage MULT/MULTU/DIV/DIVU engine. One operand bit is processed per
// clock. busy_o stalls the pipeline while an operation is in flight. flush_i
// abandons it without touching hi_o/lo_o.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-low reset
//   start_i     request an operation (sampled in IDLE only)
//   op_i        00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   data1_i     multiplicand / dividend
//   data2_i     multiplier / divisor
//   flush_i     abort the operation in flight (wins over start_i in IDLE)
//   busy_o      high while an operation is in flight
//   done_o      one-cycle pulse when hi_o/lo_o take a new result
//   div_zero_o  high with done_o when the divisor was zero
//   hi_o        product upper half / remainder
//   lo_o        product lower half / quotient
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  // Shared work register: multiply keeps {partial product, remaining multiplier},
  // divide keeps {partial remainder, dividend bits shifting out / quotient shifting in}.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;      // multiplicand or divisor magnitude
  logic               is_div;
  logic               neg_res;  // product / quotient sign
  logic               neg_rem;  // remainder follows dividend sign
  logic               dz;

  logic               sign1;
  logic               sign2;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign busy_o = (state != ST_IDLE);

  always_comb begin
    sign1 = op_i[0] & data1_i[WIDTH-1];
    sign2 = op_i[0] & data2_i[WIDTH-1];
    mag1  = sign1 ? -data1_i : data1_i;
    mag2  = sign2 ? -data2_i : data2_i;

    // Shift-add: add multiplicand on multiplier LSB, then shift the whole pair right.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide: the true difference is below 2^WIDTH, so a WIDTH-bit subtract suffices.
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb});
    div_diff  = div_shift[WIDTH-1:0] - opb;
    div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};

    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      acc        <= '0;
      opb        <= '0;
      is_div     <= 1'b0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      dz         <= 1'b0;
      done_o     <= 1'b0;
      div_zero_o <= 1'b0;
      hi_o       <= '0;
      lo_o       <= '0;
    end else begin
      done_o     <= 1'b0;
      div_zero_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i && !flush_i) begin
            is_div  <= op_i[1];
            neg_res <= sign1 ^ sign2;
            neg_rem <= sign1;
            opb     <= mag2;
            cnt     <= CW'(WIDTH);
            if (op_i[1] && (data2_i == '0)) begin
              // Raw dividend kept so FIX can return it unchanged in hi_o.
              dz    <= 1'b1;
              acc   <= {{WIDTH{1'b0}}, data1_i};
              state <= ST_FIX;
            end else begin
              dz    <= 1'b0;
              acc   <= {{WIDTH{1'b0}}, mag1};
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (flush_i) begin
            state <= ST_IDLE;
          end else begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          if (!flush_i) begin
            done_o     <= 1'b1;
            div_zero_o <= dz;
            if (dz) begin
              hi_o <= acc[WIDTH-1:0];
              lo_o <= '1;
            end else if (is_div) begin
              hi_o <= rem_fix;
              lo_o <= quo_fix;
            end else begin
              hi_o <= prod_fix[2*WIDTH-1:WIDTH];
              lo_o <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard testbench for mult_div_unit
module tb_mult_div_unit;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic        div_zero_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .data1_i(data1_i), .data2_i(data2_i), .flush_i(flush_i),
    .busy_o(busy_o), .done_o(done_o), .div_zero_o(div_zero_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    e.dz = 1'b0;
    case (op)
      2'b00: begin
        p = {32'b0, a} * {32'b0, b};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      2'b01: begin
        p = sa * sb;
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          e.hi = a;
          e.lo = 32'hFFFF_FFFF;
          e.dz = 1'b1;
        end else if (op == 2'b10) begin
          e.lo = a / b;
          e.hi = a % b;
        end else begin
          q = sa / sb;
          r = sa % sb;
          e.lo = q[31:0];
          e.hi = r[31:0];
        end
      end
    endcase
    return e;
  endfunction

  task automatic push_exp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = model(op, a, b);
    sb_q.push_back(e);
    last_hi = e.hi;
    last_lo = e.lo;
  endtask

  // Monitor: every done_o pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rst_i && done_o) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("hi", {32'b0, hi_o}, {32'b0, mon_e.hi});
        chk("lo", {32'b0, lo_o}, {32'b0, mon_e.lo});
        chk("div_zero", {63'b0, div_zero_o}, {63'b0, mon_e.dz});
        chk("busy_at_done", {63'b0, busy_o}, 64'd0);
      end
    end else if (rst_i && div_zero_o) begin
      chk("div_zero_without_done", 64'd1, 64'd0);
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    int lat;
    bit seen;
    bit busy_ok;
    lat = (op[1] && b == 32'd0) ? 1 : 33;
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; data1_i = a; data2_i = b;
    push_exp(op, a, b);
    n = 0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && n < 100) begin
      @(negedge clk_i);
      n++;
      if (n == 1) start_i = 1'b0;
      if (done_o) seen = 1'b1;
      else if (!busy_o) busy_ok = 1'b0;
    end
    chk("done_seen", {63'b0, seen}, 64'd1);
    chk("latency", 64'(n - 1), 64'(lat));
    chk("busy_during_op", {63'b0, busy_ok}, 64'd1);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    int n1;
    int n2;
    int d0;
    bit saw_done;
    rst_i = 1'b0; start_i = 1'b0; op_i = 2'b00; data1_i = '0; data2_i = '0; flush_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("reset_outputs", {busy_o, done_o, div_zero_o, hi_o, lo_o}, 64'd0);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("idle_after_reset", {63'b0, busy_o}, 64'd0);

    // Directed values
    run_op(2'b00, 32'hFFFF_FFFF, 32'd2);
    chk("multu_hi_const", {32'b0, hi_o}, 64'h1);
    chk("multu_lo_const", {32'b0, lo_o}, 64'hFFFF_FFFE);
    run_op(2'b01, -32'sd3, 32'd5);
    run_op(2'b11, -32'sd7, 32'd2);
    run_op(2'b11, 32'd7, -32'sd2);
    chk("div_rem_const", {32'b0, hi_o}, 64'd1);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_min_quot", {32'b0, lo_o}, 64'h8000_0000);
    run_op(2'b10, 32'd100, 32'd0);
    chk("divu_zero_hi", {32'b0, hi_o}, 64'd100);
    run_op(2'b11, -32'sd5, 32'd0);

    // Flush mid-CALC: no done, results unchanged
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b00; data1_i = 32'h1234_5678; data2_i = 32'h9ABC_DEF0;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    chk("busy_after_flush", {63'b0, busy_o}, 64'd0);
    d0 = done_cnt;
    repeat (40) @(negedge clk_i);
    chk("no_done_after_flush", 64'(done_cnt - d0), 64'd0);
    chk("hi_kept_after_flush", {32'b0, hi_o}, {32'b0, last_hi});
    chk("lo_kept_after_flush", {32'b0, lo_o}, {32'b0, last_lo});

    // Flush and start together in IDLE: nothing starts
    @(negedge clk_i);
    start_i = 1'b1; flush_i = 1'b1; op_i = 2'b01; data1_i = 32'd3; data2_i = 32'd3;
    @(negedge clk_i);
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush_beats_start", {63'b0, busy_o}, 64'd0);

    // Start while busy is ignored
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b00; data1_i = 32'd5; data2_i = 32'd7;
    push_exp(2'b00, 32'd5, 32'd7);
    @(negedge clk_i);
    start_i = 1'b0;
    d0 = done_cnt;
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b10; data1_i = 32'd9; data2_i = 32'd0;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (60) @(negedge clk_i);
    chk("ignored_start_dones", 64'(done_cnt - d0), 64'd1);
    chk("queue_empty_after_ignore", 64'(sb_q.size()), 64'd0);

    // Back-to-back with start held across done_o
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b01; data1_i = 32'hFFFF_FFF0; data2_i = 32'd1000;
    push_exp(2'b01, 32'hFFFF_FFF0, 32'd1000);
    push_exp(2'b11, 32'd12345, -32'sd17);
    n = 0; n1 = 0; n2 = 0;
    while (n2 == 0 && n < 200) begin
      @(negedge clk_i);
      n++;
      if (n == 1) begin op_i = 2'b11; data1_i = 32'd12345; data2_i = -32'sd17; end
      if (done_o && n1 == 0) n1 = n;
      else if (done_o) n2 = n;
      if (n1 != 0 && n == n1 + 1) start_i = 1'b0;
    end
    chk("b2b_first_done", 64'(n1), 64'd34);
    chk("b2b_second_done", 64'(n2), 64'd68);

    // Async reset mid-CALC
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b10; data1_i = 32'd1000; data2_i = 32'd7;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    chk("async_reset_outputs", {busy_o, done_o, div_zero_o, hi_o, lo_o}, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    last_hi = '0; last_lo = '0;
    run_op(2'b10, 32'd1000, 32'd7);

    // Randomized against the reference model
    for (int op = 0; op < 4; op++) begin
      for (int i = 0; i < 150; i++) begin
        run_op(2'(op), rnd_val(), rnd_val());
      end
    end

    saw_done = 1'b0;
    repeat (5) @(negedge clk_i);
    chk("queue_empty_at_end", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
